// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFault
    } fetch_state_e;

    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [1:0]  ALIGN_MASK       = 2'(INSTR_BYTES - 1);
    localparam int unsigned FETCH_XLEN       = 32;
    localparam int unsigned FETCH_ADDR_WIDTH = 32;

    // Buffer entry layout: PC in the upper bits, instruction word in the lower bits.
    typedef struct packed {
        logic [FETCH_ADDR_WIDTH-1:0] pc;
        logic [FETCH_XLEN-1:0]       instr;
    } fetch_entry_t;

    function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
        return |(addr_lsbs & ALIGN_MASK);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO with push, pop and flush; the head reads zero while the buffer is empty.
module fetch_buffer #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 64,
    localparam int unsigned CntW = $clog2(Depth) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CntW-1:0]  count,
    output logic [Width-1:0] head
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count_q != CntW'(Depth));
    assign do_pop  = pop && (count_q != '0);

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr_q] <= push_data;
                wr_ptr_q      <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign count = count_q;
    assign head  = (count_q != '0) ? mem[rd_ptr_q] : '0;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: PC, fetch FSM, redirect handling and fetch buffer.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int unsigned            XLEN       = FETCH_XLEN,
    parameter int unsigned            ADDR_WIDTH = FETCH_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0,
    parameter int unsigned            BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [XLEN-1:0]       imem_instr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic                  fetch_fault,
    output logic [31:0]           perf_fetch_cnt,
    output logic [31:0]           perf_stall_cnt
);

    localparam int unsigned EntryW = ADDR_WIDTH + XLEN;
    localparam int unsigned CntW   = $clog2(BUF_DEPTH) + 1;

    fetch_state_e          state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic                  fault_q;
    logic [CntW-1:0]       count;
    logic [EntryW-1:0]     head;
    logic                  misaligned;
    logic                  fetch;
    logic                  pop;

    assign misaligned = is_misaligned(redirect_pc[1:0]);
    // Redirect outranks both fetch and dequeue.
    assign fetch = (state_q == StRun) && fetch_en && (count < CntW'(BUF_DEPTH)) && !redirect_valid;
    assign pop   = out_valid && out_ready && !redirect_valid;

    fetch_buffer #(
        .Depth (BUF_DEPTH),
        .Width (EntryW)
    ) u_buffer (
        .clk       (clk),
        .rst       (rst),
        .push      (fetch),
        .push_data ({pc_q, imem_instr}),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (count),
        .head      (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else if (redirect_valid) begin
            pc_q <= redirect_pc;
            if (misaligned) begin
                state_q <= StFault;
                fault_q <= 1'b1;
            end else begin
                fault_q <= 1'b0;
                case (state_q)
                    StFault: state_q <= StRun;
                    StRun:   state_q <= fetch_en ? StRun : StIdle;
                    default: state_q <= StIdle;
                endcase
            end
        end else begin
            case (state_q)
                StIdle:  if (fetch_en) state_q <= StRun;
                StRun:   if (!fetch_en) state_q <= StIdle;
                default: state_q <= state_q;
            endcase
            if (fetch) begin
                pc_q <= pc_q + ADDR_WIDTH'(INSTR_BYTES);
            end
        end
    end

    assign imem_addr   = pc_q;
    assign out_valid   = (count != '0);
    assign out_pc      = head[EntryW-1 -: ADDR_WIDTH];
    assign out_instr   = head[XLEN-1:0];
    assign fetch_fault = fault_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;
    logic        stall;

    assign stall = (state_q == StRun) && fetch_en && (count == CntW'(BUF_DEPTH)) && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (fetch) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`else
    assign perf_fetch_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Directed, table-driven bench for fetch_controller with hand-written multi-cycle sequences.
module tb_fetch_controller;

`ifdef FETCH_PERF_CNT_EN
    localparam bit PerfOn = 1'b1;
`else
    localparam bit PerfOn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fetch_fault;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Memory model: word i (address 4*i) holds 0x1000 + i.
    assign imem_instr = 32'h1000 + {2'b00, imem_addr[31:2]};

    fetch_controller dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fetch_fault    (fetch_fault),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );

    typedef struct {
        logic        fe;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic [31:0] eaddr;
        logic        efault;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive inputs just after a falling edge; outputs then reflect the previous rising edge.
    task automatic step(input logic r, input logic fe, input logic rv, input logic [31:0] rpc,
                        input logic rdy);
        @(negedge clk);
        rst            = r;
        fetch_en       = fe;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, " addr"}, imem_addr, 32'd0);
        chk({tag, " pc"}, out_pc, 32'd0);
        chk({tag, " instr"}, out_instr, 32'd0);
        chk({tag, " fault"}, {31'd0, fetch_fault}, 32'd0);
        chk({tag, " perf_fetch"}, perf_fetch_cnt, 32'd0);
        chk({tag, " perf_stall"}, perf_stall_cnt, 32'd0);
    endtask

    initial begin
        //            fe    rv    rpc           rdy   ev    epc     einstr     eaddr   efault
        vecs[0]  = '{1'b1, 1'b0, 32'h0,       1'b1, 1'b0, 32'h0,  32'h0,    32'h0,  1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0,       1'b1, 1'b0, 32'h0,  32'h0,    32'h0,  1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,       1'b1, 1'b1, 32'h0,  32'h1000, 32'h4,  1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,       1'b1, 1'b1, 32'h4,  32'h1001, 32'h8,  1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,       1'b0, 1'b1, 32'h8,  32'h1002, 32'hC,  1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,       1'b0, 1'b1, 32'h8,  32'h1002, 32'h10, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 32'h0,       1'b1, 1'b1, 32'h8,  32'h1002, 32'h10, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,       1'b1, 1'b1, 32'hC,  32'h1003, 32'h10, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 32'h0,       1'b0, 1'b1, 32'h10, 32'h1004, 32'h14, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 32'h40,      1'b0, 1'b1, 32'h10, 32'h1004, 32'h18, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 32'h0,       1'b1, 1'b0, 32'h0,  32'h0,    32'h40, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 32'h0,       1'b1, 1'b1, 32'h40, 32'h1010, 32'h44, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 32'h0,       1'b1, 1'b1, 32'h44, 32'h1011, 32'h48, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 32'h0,       1'b1, 1'b1, 32'h48, 32'h1012, 32'h4C, 1'b0};

        // Two reset cycles; the second also raises a redirect, which reset must override.
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h100, 1'b0);

        for (int i = 0; i < 14; i++) begin
            step(1'b0, vecs[i].fe, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
            chk($sformatf("row%0d valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ev});
            chk($sformatf("row%0d pc", i), out_pc, vecs[i].epc);
            chk($sformatf("row%0d instr", i), out_instr, vecs[i].einstr);
            chk($sformatf("row%0d addr", i), imem_addr, vecs[i].eaddr);
            chk($sformatf("row%0d fault", i), {31'd0, fetch_fault}, {31'd0, vecs[i].efault});
        end

        // Misaligned redirect: fault raised, no fetches while it persists.
        step(1'b0, 1'b1, 1'b1, 32'h42, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
            chk($sformatf("fault%0d valid", i), {31'd0, out_valid}, 32'd0);
            chk($sformatf("fault%0d flag", i), {31'd0, fetch_fault}, 32'd1);
            chk($sformatf("fault%0d addr", i), imem_addr, 32'h42);
        end
        step(1'b0, 1'b0, 1'b1, 32'h80, 1'b1);
        chk("fault held before redirect", {31'd0, fetch_fault}, 32'd1);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("fault cleared", {31'd0, fetch_fault}, 32'd0);
        chk("recover addr", imem_addr, 32'h80);
        chk("recover valid", {31'd0, out_valid}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("recover pc", out_pc, 32'h80);
        chk("recover instr", out_instr, 32'h1020);

        // PC wrap across the top of the address space.
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("wrap addr top", imem_addr, 32'hFFFF_FFFC);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("wrap pc top", out_pc, 32'hFFFF_FFFC);
        chk("wrap instr top", out_instr, 32'h4000_0FFF);
        chk("wrap addr zero", imem_addr, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("wrap pc zero", out_pc, 32'h0);
        chk("wrap instr zero", out_instr, 32'h1000);

        // Reset mid-stream, then backpressure from a clean start.
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk_reset_state("midrst");
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        end
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("bp valid", {31'd0, out_valid}, 32'd1);
        chk("bp pc0", out_pc, 32'h0);
        chk("bp addr held", imem_addr, 32'h8);
        chk("bp perf_stall", perf_stall_cnt, PerfOn ? 32'd3 : 32'd0);
        chk("bp perf_fetch", perf_fetch_cnt, PerfOn ? 32'd2 : 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("bp pc1", out_pc, 32'h4);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("bp pc2", out_pc, 32'h8);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("bp pc3", out_pc, 32'hC);

        // Redirect while idle loads the PC but does not leave idle, even with fetch_en high.
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 32'h20, 1'b1);
        chk_reset_state("rst2");
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("idle redir addr", imem_addr, 32'h20);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("idle redir no fetch", {31'd0, out_valid}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("idle redir valid", {31'd0, out_valid}, 32'd1);
        chk("idle redir pc", out_pc, 32'h20);
        chk("idle redir instr", out_instr, 32'h1008);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
